// File: rtl/bist_pkg.sv
// bist_pkg: FSM state encoding and counter sizing helper for the logic-BIST controller.
package bist_pkg;
  localparam logic [2:0] IDLE = 3'd0, INIT = 3'd1, RUN = 3'd2, FLUSH = 3'd3, COMPARE = 3'd4, DONE = 3'd5;
  function automatic int cnt_bits(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/bist_delay_line.sv
// bist_delay_line: DEPTH-cycle delay of a 1-bit strobe; DEPTH=0 degenerates to a wire.
module bist_delay_line #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr_i,
  input  logic d_i,
  output logic q_o
);
  if (DEPTH == 0) begin : g_wire
    logic unused_ok;
    assign unused_ok = clk ^ reset_n ^ clr_i;
    assign q_o = d_i;
  end else begin : g_sr
    logic [DEPTH-1:0] sr_q;
    always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) sr_q <= '0;
      else sr_q <= clr_i ? '0 : (sr_q << 1) | DEPTH'(d_i);
    assign q_o = sr_q[DEPTH-1];
  end
endmodule

// File: rtl/bist_controller.sv
// bist_controller: sequences one LFSR/MISR logic-BIST session and checks the final signature.
module bist_controller import bist_pkg::*; #(
  parameter int N_PATTERNS = 256,
  parameter int CNT_W = 16,
  parameter int CUT_LAT = 2,
  parameter int SIG_W = 121,
  parameter logic [SIG_W-1:0] GOLDEN = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [SIG_W-1:0] signature,
  output logic             lfsr_init,
  output logic             lfsr_en,
  output logic             misr_init,
  output logic             misr_en,
  output logic             test_mode,
  output logic             busy,
  output logic             done,
  output logic             pass
);
  if (N_PATTERNS < 1 || CNT_W < cnt_bits(N_PATTERNS) || CUT_LAT < 0 || CUT_LAT > 15) begin : g_bad_cfg
    $error("bist_controller: N_PATTERNS/CNT_W/CUT_LAT out of range");
  end
  logic [2:0] state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic init_q, lfsr_en_q, act_q, done_q, pass_q, pass_d;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    if (abort) begin
      state_d = IDLE;
      cnt_d = '0;
    end else begin
      case (state_q)
        IDLE:    state_d = start ? INIT : IDLE;
        INIT:    begin state_d = RUN; cnt_d = '0; end
        RUN:     if (cnt_q == CNT_W'(N_PATTERNS - 1)) begin
                   state_d = (CUT_LAT == 0) ? COMPARE : FLUSH;
                   cnt_d = '0;
                 end else cnt_d = cnt_q + 1'b1;
        FLUSH:   if (cnt_q == CNT_W'(CUT_LAT - 1)) begin
                   state_d = COMPARE;
                   cnt_d = '0;
                 end else cnt_d = cnt_q + 1'b1;
        COMPARE: state_d = DONE;
        DONE:    state_d = start ? INIT : DONE;
        default: state_d = IDLE;
      endcase
    end
  end
  // pass latches the comparison on COMPARE->DONE and survives only while DONE persists
  assign pass_d = (state_d == DONE) & ((state_q == COMPARE) ? (signature == GOLDEN) : pass_q);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      init_q <= 1'b0;
      lfsr_en_q <= 1'b0;
      act_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      init_q <= state_d == INIT;
      lfsr_en_q <= state_d == RUN;
      act_q <= state_d inside {INIT, RUN, FLUSH, COMPARE};
      done_q <= state_d == DONE;
      pass_q <= pass_d;
    end
  bist_delay_line #(.DEPTH(CUT_LAT)) u_delay (
    .clk(clk), .reset_n(reset_n), .clr_i(abort), .d_i(lfsr_en_q), .q_o(misr_en)
  );
  assign lfsr_init = init_q;
  assign misr_init = init_q;
  assign lfsr_en = lfsr_en_q;
  assign test_mode = act_q;
  assign busy = act_q;
  assign done = done_q;
  assign pass = pass_q;
endmodule

// File: tb/tb_bist_controller.sv
// tb_bist_controller: scoreboard bench with LFSR/CUT/MISR models around three controller instances.
module tb_bist_controller;
  localparam logic [15:0] SEED = 16'hACE1;
  function automatic logic [15:0] lstep(input logic [15:0] x);
    return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
  endfunction
  function automatic logic [15:0] mstep(input logic [15:0] x);
    return {x[14:0], x[15] ^ x[14] ^ x[12] ^ x[3]};
  endfunction
  function automatic logic [15:0] cutf(input logic [15:0] x);
    return x ^ {x[10:0], 5'b0} ^ 16'h5A5A;
  endfunction
  function automatic logic [15:0] golden();
    logic [15:0] l, m;
    l = SEED;
    m = '0;
    for (int j = 0; j < 8; j++) begin
      m = mstep(m) ^ cutf(l);
      l = lstep(l);
    end
    return m;
  endfunction
  localparam logic [15:0] GOLD = golden();
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [2:0] st = '0, ab = '0;
  logic [2:0] li, le, mi, me, tm, bz, dn, ps;
  logic [15:0] lfsr [3], p1 [3], p2 [3], misr [3], cut [3];
  int cyc = 0;
  int n_chk = 0, n_pass = 0;
  typedef struct {int inst; int pass; int lat; int fm;} exp_t;
  exp_t sbq[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  bist_controller #(.N_PATTERNS(8), .CNT_W(4), .CUT_LAT(2), .SIG_W(16), .GOLDEN(GOLD)) u_a (
    .clk(clk), .reset_n(reset_n), .start(st[0]), .abort(ab[0]), .signature(misr[0]),
    .lfsr_init(li[0]), .lfsr_en(le[0]), .misr_init(mi[0]), .misr_en(me[0]),
    .test_mode(tm[0]), .busy(bz[0]), .done(dn[0]), .pass(ps[0]));
  bist_controller #(.N_PATTERNS(8), .CNT_W(4), .CUT_LAT(2), .SIG_W(16), .GOLDEN(GOLD ^ 16'h0001)) u_b (
    .clk(clk), .reset_n(reset_n), .start(st[1]), .abort(ab[1]), .signature(misr[1]),
    .lfsr_init(li[1]), .lfsr_en(le[1]), .misr_init(mi[1]), .misr_en(me[1]),
    .test_mode(tm[1]), .busy(bz[1]), .done(dn[1]), .pass(ps[1]));
  bist_controller #(.N_PATTERNS(8), .CNT_W(4), .CUT_LAT(0), .SIG_W(16), .GOLDEN(GOLD)) u_c (
    .clk(clk), .reset_n(reset_n), .start(st[2]), .abort(ab[2]), .signature(misr[2]),
    .lfsr_init(li[2]), .lfsr_en(le[2]), .misr_init(mi[2]), .misr_en(me[2]),
    .test_mode(tm[2]), .busy(bz[2]), .done(dn[2]), .pass(ps[2]));
  // instances 0/1 see a 2-stage CUT pipeline, instance 2 a combinational CUT
  assign cut[0] = p2[0];
  assign cut[1] = p2[1];
  assign cut[2] = cutf(lfsr[2]);
  always @(posedge clk or negedge reset_n)
    for (int i = 0; i < 3; i++)
      if (!reset_n) begin
        lfsr[i] <= '0; p1[i] <= '0; p2[i] <= '0; misr[i] <= '0;
      end else begin
        lfsr[i] <= li[i] ? SEED : le[i] ? lstep(lfsr[i]) : lfsr[i];
        p1[i] <= cutf(lfsr[i]);
        p2[i] <= p1[i];
        misr[i] <= mi[i] ? '0 : me[i] ? (mstep(misr[i]) ^ cut[i]) : misr[i];
      end
  function automatic void chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endfunction
  int t0 [3], nl [3], nm [3], fl [3], fm [3];
  logic [2:0] dprev = '0;
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (li[i]) begin
        t0[i] = cyc; nl[i] = 0; nm[i] = 0; fl[i] = -1; fm[i] = -1;
      end
      if (le[i]) begin
        if (fl[i] < 0) fl[i] = cyc - t0[i];
        nl[i]++;
      end
      if (me[i]) begin
        if (fm[i] < 0) fm[i] = cyc - t0[i];
        nm[i]++;
      end
      if (dn[i] && !dprev[i]) begin
        if (sbq.size() == 0) chk("unexpected_done", i, -1);
        else begin
          exp_t e;
          e = sbq.pop_front();
          chk("done_inst", i, e.inst);
          chk("pass", int'(ps[i]), e.pass);
          chk("done_latency", cyc - t0[i], e.lat);
          chk("lfsr_en_first", fl[i], 1);
          chk("lfsr_en_count", nl[i], 8);
          chk("misr_en_first", fm[i], e.fm);
          chk("misr_en_count", nm[i], 8);
        end
      end
      dprev[i] = dn[i];
    end
  end
  task automatic pulse(input int i);
    @(negedge clk); st[i] = 1'b1;
    @(negedge clk); st[i] = 1'b0;
  endtask
  task automatic drain(input int budget);
    int k = 0;
    while (sbq.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (sbq.size() != 0) begin
      n_chk++;
      $display("FAIL drain_timeout: %0d pending, expected 0", sbq.size());
      sbq.delete();
    end
  endtask
  initial begin
    #1;
    for (int i = 0; i < 3; i++)
      chk("reset_outputs", int'({li[i], le[i], mi[i], me[i], tm[i], bz[i], dn[i], ps[i]}), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    sbq.push_back('{0, 1, 12, 3});
    pulse(0);
    drain(40);
    sbq.push_back('{1, 0, 12, 3});
    pulse(1);
    drain(40);
    pulse(0);
    repeat (4) @(negedge clk);
    ab[0] = 1'b1;
    @(negedge clk); ab[0] = 1'b0;
    @(negedge clk);
    chk("abort_outputs", int'({le[0], me[0], tm[0], bz[0], dn[0], ps[0]}), 0);
    sbq.push_back('{0, 1, 12, 3});
    pulse(0);
    drain(40);
    sbq.push_back('{0, 1, 12, 3});
    pulse(0);
    repeat (2) @(negedge clk);
    st[0] = 1'b1;
    @(negedge clk); st[0] = 1'b0;
    repeat (3) @(negedge clk);
    st[0] = 1'b1;
    @(negedge clk); st[0] = 1'b0;
    drain(40);
    pulse(0);
    repeat (5) @(negedge clk);
    @(posedge clk);
    chk("run_before_reset", int'({le[0], bz[0]}), 3);
    #2 reset_n = 1'b0;
    #1 chk("async_reset_outputs", int'({li[0], le[0], mi[0], me[0], tm[0], bz[0], dn[0], ps[0]}), 0);
    @(negedge clk); reset_n = 1'b1;
    sbq.push_back('{0, 1, 12, 3});
    pulse(0);
    drain(40);
    sbq.push_back('{2, 1, 10, 1});
    pulse(2);
    drain(40);
    chk("c_done_held", int'({dn[2], ps[2]}), 3);
    sbq.push_back('{2, 1, 10, 1});
    pulse(2);
    chk("restart_clears_done", int'({dn[2], ps[2], bz[2]}), 1);
    drain(40);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
